multi_port_ram: RTL and testbench

- Shared single-bank word RAM serving NUM_PORTS independent requesters through a round-robin arbiter.
- Each port uses the team's read/write/complete handshake.
- Every access takes a programmable DELAY cycles, modelling slow main memory behind caches or DMA masters.
- Adds multi-channel arbitration, request capture, out-of-range reporting and a busy indication to the single-port delayed RAM.

---
 rtl/multi_port_ram.sv | 164 ++++++++++++++++
 tb/tb_multi_port_ram.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_port_ram.sv
// multi_port_ram: one shared word RAM behind a round-robin arbiter. Each access
// is captured at accept, committed DELAY edges later, then signalled by a
// one-cycle completion pulse on the granted port.
module multi_port_ram #(
  parameter int    DATA_WIDTH    = 32,
  parameter int    ADDRESS_WIDTH = 16,
  parameter int    SIZE_IN_WORDS = 1024,
  parameter int    NUM_PORTS     = 2,
  parameter int    DELAY         = 4,
  parameter int    COUNTER_WIDTH = $clog2(DELAY + 1),
  parameter int    PORT_WIDTH    = $clog2(NUM_PORTS),
  parameter string INIT_FILE     = "",
  parameter bit    IS_TEST       = 1'b0
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_PORTS-1:0]              readEnabled,
  input  logic [NUM_PORTS-1:0]              writeEnabled,
  input  logic [NUM_PORTS*ADDRESS_WIDTH-1:0] address,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   dataOut,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]   dataIn,
  output logic [NUM_PORTS-1:0]              functionComplete,
  output logic [NUM_PORTS-1:0]              addressError,
  output logic                              busy,
  output logic [PORT_WIDTH-1:0]             grantedPort
);

  localparam int MEM_AW = (SIZE_IN_WORDS > 1) ? $clog2(SIZE_IN_WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                          r_state;
  state_t                          w_state_next;
  logic [COUNTER_WIDTH-1:0]        r_counter;
  logic [PORT_WIDTH-1:0]           r_ptr;
  logic [PORT_WIDTH-1:0]           r_granted;
  logic                            r_op_write;
  logic [ADDRESS_WIDTH-1:0]        r_addr;
  logic [DATA_WIDTH-1:0]           r_wdata;
  logic [NUM_PORTS*DATA_WIDTH-1:0] r_data_in;
  logic [NUM_PORTS-1:0]            r_complete;
  logic [NUM_PORTS-1:0]            r_error;

  logic [NUM_PORTS-1:0]            w_req;
  logic                            w_any_req;
  logic                            w_accept;
  logic                            w_commit;
  logic                            w_in_range;
  logic [MEM_AW-1:0]               w_mem_idx;
  logic [PORT_WIDTH-1:0]           w_pick;
  logic [PORT_WIDTH-1:0]           w_pick_hi;
  logic [PORT_WIDTH-1:0]           w_pick_lo;
  logic                            w_found_hi;
  logic [PORT_WIDTH-1:0]           w_ptr_next;

  logic [DATA_WIDTH-1:0] r_mem [SIZE_IN_WORDS];

  // Optional time-zero contents: all zeros for test builds.
  generate
    if ((INIT_FILE == "") && IS_TEST) begin : g_init_zero
      initial begin
        for (int i = 0; i < SIZE_IN_WORDS; i++) r_mem[i] = '0;
      end
    end
  endgenerate

  assign w_req      = readEnabled | writeEnabled;
  assign w_any_req  = |w_req;
  assign w_accept   = (r_state == S_IDLE) && w_any_req;
  assign w_in_range = ({1'b0, r_addr} < (ADDRESS_WIDTH + 1)'(SIZE_IN_WORDS));
  assign w_mem_idx  = r_addr[MEM_AW-1:0];
  assign w_ptr_next = (w_pick == PORT_WIDTH'(NUM_PORTS - 1)) ? '0 : w_pick + PORT_WIDTH'(1);

  // Round-robin pick: lowest requester at or above the pointer, else lowest overall.
  always_comb begin
    w_pick_hi  = '0;
    w_pick_lo  = '0;
    w_found_hi = 1'b0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (w_req[k]) begin
        w_pick_lo = PORT_WIDTH'(k);
        if (k >= int'(r_ptr)) begin
          w_pick_hi  = PORT_WIDTH'(k);
          w_found_hi = 1'b1;
        end
      end
    end
    w_pick = w_found_hi ? w_pick_hi : w_pick_lo;
  end

  // Next-state decode; the commit strobe fires on the last BUSY edge.
  always_comb begin
    w_state_next = r_state;
    w_commit     = 1'b0;
    case (r_state)
      S_IDLE: if (w_any_req) w_state_next = S_BUSY;
      S_BUSY: begin
        if (r_counter == '0) begin
          w_state_next = S_DONE;
          w_commit     = 1'b1;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register; reset aborts any access in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Request capture, delay count, read return and completion/error pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_counter  <= '0;
      r_ptr      <= '0;
      r_granted  <= '0;
      r_op_write <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_data_in  <= '0;
      r_complete <= '0;
      r_error    <= '0;
    end else begin
      r_complete <= '0;
      r_error    <= '0;
      if (w_accept) begin
        r_granted  <= w_pick;
        r_ptr      <= w_ptr_next;
        r_op_write <= writeEnabled[w_pick];
        r_addr     <= address[w_pick*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        r_wdata    <= dataOut[w_pick*DATA_WIDTH +: DATA_WIDTH];
        r_counter  <= COUNTER_WIDTH'(DELAY - 1);
      end else if ((r_state == S_BUSY) && (r_counter != '0)) begin
        r_counter <= r_counter - COUNTER_WIDTH'(1);
      end
      if (w_commit) begin
        r_complete[r_granted] <= 1'b1;
        r_error[r_granted]    <= !w_in_range;
        if (!r_op_write) begin
          r_data_in[r_granted*DATA_WIDTH +: DATA_WIDTH] <= w_in_range ? r_mem[w_mem_idx] : '0;
        end
      end
    end
  end

  // Memory write port; contents survive reset.
  always_ff @(posedge clock) begin
    if (w_commit && r_op_write && w_in_range) r_mem[w_mem_idx] <= r_wdata;
  end

  assign dataIn           = r_data_in;
  assign functionComplete = r_complete;
  assign addressError     = r_error;
  assign busy             = (r_state != S_IDLE);
  assign grantedPort      = r_granted;

endmodule

// File: tb/tb_multi_port_ram.sv
// Bench for multi_port_ram: a DELAY=4 instance checked through a per-port
// scoreboard, plus a DELAY=1 instance for the shortest latency.
module tb_multi_port_ram;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int NP = 2;
  localparam int SZ = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [NP-1:0]     re, we, fc, aerr;
  logic [NP*AW-1:0]  addr;
  logic [NP*DW-1:0]  wdata, rdata;
  logic              busy;
  logic [0:0]        gp;

  logic [NP-1:0]     b_re, b_we, b_fc, b_aerr;
  logic [NP*AW-1:0]  b_addr;
  logic [NP*DW-1:0]  b_wdata, b_rdata;
  logic              b_busy;
  logic [0:0]        b_gp;

  multi_port_ram #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .SIZE_IN_WORDS(SZ),
                   .NUM_PORTS(NP), .DELAY(4), .IS_TEST(1'b1)) u_dut (
    .clock(clk), .reset(rst_n), .readEnabled(re), .writeEnabled(we),
    .address(addr), .dataOut(wdata), .dataIn(rdata), .functionComplete(fc),
    .addressError(aerr), .busy(busy), .grantedPort(gp));

  multi_port_ram #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .SIZE_IN_WORDS(SZ),
                   .NUM_PORTS(NP), .DELAY(1), .IS_TEST(1'b1)) u_dut1 (
    .clock(clk), .reset(rst_n), .readEnabled(b_re), .writeEnabled(b_we),
    .address(b_addr), .dataOut(b_wdata), .dataIn(b_rdata), .functionComplete(b_fc),
    .addressError(b_aerr), .busy(b_busy), .grantedPort(b_gp));

  typedef struct {
    logic          is_read;
    logic          err;
    logic [DW-1:0] data;
  } exp_t;

  int            n_cmp = 0;
  int            n_err = 0;
  exp_t          exp_q [NP][$];
  exp_t          mon_e;
  logic [DW-1:0] mdl  [SZ];
  logic [DW-1:0] hold [NP];
  int            last_grant = NP - 1;

  // Reference model: applies a write, or predicts a read result.
  function automatic exp_t model_op(input bit w, input int a, input logic [DW-1:0] d);
    exp_t e;
    e.is_read = !w;
    e.err     = (a >= SZ);
    e.data    = '0;
    if (a < SZ) begin
      if (w) mdl[a] = d;
      else   e.data = mdl[a];
    end
    return e;
  endfunction

  // Scoreboard: every completion pops the port's queue and is checked.
  always @(negedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (rst_n === 1'b1 && fc[p] === 1'b1) begin
        n_cmp++;
        if (exp_q[p].size() == 0) begin
          n_err++;
          $display("FAIL unexpected_complete port %0d: got completion, required none", p);
        end else begin
          mon_e = exp_q[p].pop_front();
          if (aerr[p] !== mon_e.err) begin
            n_err++;
            $display("FAIL addr_error port %0d: got %b required %b", p, aerr[p], mon_e.err);
          end
          if (mon_e.is_read) hold[p] = mon_e.data;
          n_cmp++;
          if (rdata[p*DW +: DW] !== hold[p]) begin
            n_err++;
            $display("FAIL data_in port %0d: got %h required %h", p, rdata[p*DW +: DW], hold[p]);
          end
          $display("port %0d %s err=%b dataIn=%h", p, mon_e.is_read ? "read " : "write",
                   aerr[p], rdata[p*DW +: DW]);
        end
      end
    end
  end

  task automatic wait_complete(input int p, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (fc[p] === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s timeout port %0d: got no completion, required one within 40 cycles", name, p);
    end
  endtask

  task automatic access(input int p, input bit w, input bit r, input int a, input logic [DW-1:0] d);
    @(posedge clk); #1;
    we[p] = w;
    re[p] = r;
    addr[p*AW +: AW]  = AW'(a);
    wdata[p*DW +: DW] = d;
    exp_q[p].push_back(model_op(w, a, d));
    last_grant = p;
    wait_complete(p, "access");
    we[p] = 1'b0;
    re[p] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp += 6;
    if (rdata !== '0) begin n_err++; $display("FAIL reset_dataIn: got %h required 0", rdata); end
    if (fc !== '0)    begin n_err++; $display("FAIL reset_complete: got %b required 0", fc); end
    if (aerr !== '0)  begin n_err++; $display("FAIL reset_error: got %b required 0", aerr); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b required 0", busy); end
    if (gp !== 1'b0)  begin n_err++; $display("FAIL reset_grant: got %b required 0", gp); end
    if (b_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy_d1: got %b required 0", b_busy); end
    rst_n = 1'b1;
    $display("reset released");
  endtask

  task automatic test_latency();
    @(posedge clk); #1;
    we[0] = 1'b1;
    addr[0 +: AW]  = AW'(5);
    wdata[0 +: DW] = 32'hDEADBEEF;
    exp_q[0].push_back(model_op(1'b1, 5, 32'hDEADBEEF));
    last_grant = 0;
    @(posedge clk);  // accept edge
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_cmp += 2;
      if (fc[0] !== (k == 4)) begin
        n_err++; $display("FAIL latency_complete cycle %0d: got %b required %b", k, fc[0], (k == 4));
      end
      if (busy !== (k < 5)) begin
        n_err++; $display("FAIL latency_busy cycle %0d: got %b required %b", k, busy, (k < 5));
      end
      if (k == 4) we[0] = 1'b0;
    end
    access(0, 1'b0, 1'b1, 5, '0);
  endtask

  task automatic test_arbitration();
    int g;
    int low_cnt = 0;
    bit prev_busy = 1'b0;
    bit got;
    bit b;
    access(0, 1'b1, 1'b0, 10, 32'h0000A0A0);
    access(1, 1'b1, 1'b0, 11, 32'h0000B1B1);
    g = (last_grant + 1) % NP;
    @(posedge clk); #1;
    re = 2'b11;
    addr[0 +: AW]  = AW'(10);
    addr[AW +: AW] = AW'(11);
    for (int n = 0; n < 4; n++) begin
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
        @(negedge clk);
        b = busy;
        if (b && !prev_busy) got = 1'b1;
        else if (!b) low_cnt++;
        prev_busy = b;
      end
      n_cmp += 2;
      if (!got) begin n_err++; $display("FAIL arb_accept %0d: got no accept, required one within 40 cycles", n); end
      if (gp !== g) begin n_err++; $display("FAIL arb_grant %0d: got %0d required %0d", n, gp, g); end
      $display("arbitration grant %0d -> port %0d", n, gp);
      exp_q[g].push_back(model_op(1'b0, (g == 0) ? 10 : 11, '0));
      if (n > 0) begin
        n_cmp++;
        if (low_cnt !== 1) begin n_err++; $display("FAIL arb_gap %0d: got %0d idle cycles required 1", n, low_cnt); end
      end
      low_cnt = 0;
      last_grant = g;
      g = (g + 1) % NP;
    end
    wait_complete(last_grant, "arbitration");
    re = 2'b00;
  endtask

  task automatic test_out_of_range();
    access(1, 1'b1, 1'b0, 1024, 32'h00000055);
    access(1, 1'b0, 1'b1, 2000, '0);
    access(0, 1'b0, 1'b1, 0, '0);
    access(1, 1'b0, 1'b1, 1023, '0);
  endtask

  task automatic test_rw_priority();
    access(0, 1'b1, 1'b1, 7, 32'h00000011);
    access(0, 1'b0, 1'b1, 7, '0);
  endtask

  task automatic test_reset_abort();
    @(posedge clk); #1;
    we[0] = 1'b1;
    addr[0 +: AW]  = AW'(3);
    wdata[0 +: DW] = 32'h00000022;
    @(posedge clk);  // accept, counter=3
    @(posedge clk);
    @(posedge clk);  // counter=1
    #2 rst_n = 1'b0;
    #1;
    n_cmp += 4;
    if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b required 0", busy); end
    if (rdata !== '0)  begin n_err++; $display("FAIL abort_dataIn: got %h required 0", rdata); end
    if (fc !== '0)     begin n_err++; $display("FAIL abort_complete: got %b required 0", fc); end
    if (gp !== 1'b0)   begin n_err++; $display("FAIL abort_grant: got %b required 0", gp); end
    we[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    hold[0] = '0;
    hold[1] = '0;
    last_grant = NP - 1;
    $display("reset abort done");
    access(0, 1'b0, 1'b1, 3, '0);
  endtask

  task automatic b_read(input int a, input logic [DW-1:0] exp_data);
    bit seen = 1'b0;
    @(posedge clk); #1;
    b_re[0] = 1'b1;
    b_addr[0 +: AW] = AW'(a);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (b_fc[0] === 1'b1) seen = 1'b1;
    end
    b_re[0] = 1'b0;
    n_cmp += 2;
    if (!seen) begin n_err++; $display("FAIL d1_read_timeout addr %0d: got no completion, required one", a); end
    if (b_rdata[0 +: DW] !== exp_data) begin
      n_err++; $display("FAIL d1_read addr %0d: got %h required %h", a, b_rdata[0 +: DW], exp_data);
    end
    $display("delay1 read addr %0d dataIn=%h", a, b_rdata[0 +: DW]);
  endtask

  task automatic test_delay1();
    @(posedge clk); #1;
    b_we[0] = 1'b1;
    b_addr[0 +: AW]  = AW'(20);
    b_wdata[0 +: DW] = 32'h00000077;
    @(posedge clk);  // accept
    @(negedge clk);
    n_cmp += 2;
    if (b_fc[0] !== 1'b0) begin n_err++; $display("FAIL d1_early_complete: got %b required 0", b_fc[0]); end
    if (b_busy !== 1'b1)  begin n_err++; $display("FAIL d1_busy: got %b required 1", b_busy); end
    b_addr[0 +: AW]  = AW'(21);
    b_wdata[0 +: DW] = 32'h00000099;
    @(negedge clk);
    n_cmp++;
    if (b_fc[0] !== 1'b1) begin n_err++; $display("FAIL d1_complete: got %b required 1", b_fc[0]); end
    b_we[0] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (b_fc[0] !== 1'b0) begin n_err++; $display("FAIL d1_pulse_width: got %b required 0", b_fc[0]); end
    $display("delay1 write addr 20 complete");
    b_read(20, 32'h00000077);
    b_read(21, 32'h00000000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    re = '0; we = '0; addr = '0; wdata = '0;
    b_re = '0; b_we = '0; b_addr = '0; b_wdata = '0;
    for (int i = 0; i < SZ; i++) mdl[i] = '0;
    for (int p = 0; p < NP; p++) hold[p] = '0;
    test_reset();
    test_latency();
    test_arbitration();
    test_out_of_range();
    test_rw_priority();
    test_reset_abort();
    test_delay1();
    repeat (3) @(negedge clk);
    for (int p = 0; p < NP; p++) begin
      n_cmp++;
      if (exp_q[p].size() != 0) begin
        n_err++;
        $display("FAIL pending_port %0d: got %0d outstanding required 0", p, exp_q[p].size());
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
